// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a valid/ready handshake.
// A 2-entry skid buffer (output + skid register) gives full throughput with registered in_ready.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:7]     Instr,
  input  logic [2:0]      ImmSrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic            ImmSrc_err
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   dec_imm, skid_imm;
  logic              dec_err, skid_err;
  logic              accept;
  logic              load_out, load_skid, pop_skid;

  // Combinational decode of the presented instruction; a size cast of a
  // $signed field sign-extends, a cast of an unsigned field zero-extends.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dec_imm = '0;
    dec_err = 1'b0;
    case (ImmSrc)
      3'b000: dec_imm = XLEN'($signed(Instr[31:20]));
      3'b001: dec_imm = XLEN'($signed({Instr[31:25], Instr[11:7]}));
      3'b010: dec_imm = XLEN'($signed({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}));
      3'b011: dec_imm = XLEN'($signed({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0}));
      3'b100: dec_imm = XLEN'($signed({Instr[31:12], 12'b0}));
      3'b101: begin
        if (XLEN == 64) begin
          dec_imm = XLEN'(Instr[25:20]);
        end else begin
          dec_imm = XLEN'(Instr[24:20]);
          dec_err = Instr[25];
        end
      end
      3'b110: dec_imm = XLEN'(Instr[19:15]);
      default: dec_err = 1'b1;
    endcase
  end

  // Ready and valid depend on the state register only: no out_ready -> in_ready path.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt = ONE;
          load_out  = 1'b1;
        end
        ONE: begin
          if (accept && out_ready) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (out_ready) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (out_ready) begin
          state_nxt = ONE;
          pop_skid  = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the data registers are reset too, because ImmExt and the skid contents must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ImmExt     <= '0;
      ImmSrc_err <= 1'b0;
      skid_imm   <= '0;
      skid_err   <= 1'b0;
    end else begin
      if (load_out) begin
        ImmExt     <= dec_imm;
        ImmSrc_err <= dec_err;
      end else if (pop_skid) begin
        ImmExt     <= skid_imm;
        ImmSrc_err <= skid_err;
      end
      if (load_skid) begin
        skid_imm <= dec_imm;
        skid_err <= dec_err;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
// Expected immediates are hand-decoded from the instruction encodings.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:7] instr;
  logic [2:0]  imm_src;
  logic        out_ready;

  logic        in_ready32, out_valid32, err32;
  logic [31:0] imm32;
  logic        in_ready64, out_valid64, err64;
  logic [63:0] imm64;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .Instr(instr), .ImmSrc(imm_src), .out_valid(out_valid32), .out_ready(out_ready),
    .ImmExt(imm32), .ImmSrc_err(err32)
  );

  imm_gen_pipe #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .Instr(instr), .ImmSrc(imm_src), .out_valid(out_valid64), .out_ready(out_ready),
    .ImmExt(imm64), .ImmSrc_err(err64)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] word, input logic [2:0] src);
    in_valid = v;
    instr    = word[31:7];
    imm_src  = src;
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both widths: valid, 32-bit result/err, 64-bit result/err.
  task automatic expect_out(input string tag, input logic [31:0] e32, input logic e_err32,
                            input logic [63:0] e64, input logic e_err64);
    check({tag, ".v32"},   64'(out_valid32), 64'd1);
    check({tag, ".imm32"}, 64'(imm32), 64'(e32));
    check({tag, ".err32"}, 64'(err32), 64'(e_err32));
    check({tag, ".v64"},   64'(out_valid64), 64'd1);
    check({tag, ".imm64"}, imm64, e64);
    check({tag, ".err64"}, 64'(err64), 64'(e_err64));
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'b000);
    #3;
    check("rst.out_valid", 64'(out_valid32), 64'd0);
    check("rst.imm32",     64'(imm32), 64'd0);
    check("rst.err32",     64'(err32), 64'd0);
    check("rst.in_ready",  64'(in_ready32), 64'd1);
    check("rst.imm64",     imm64, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Streaming with out_ready high: each result is visible one cycle after its accept.
    drive(1'b1, 32'hFFF00093, 3'b000); tick();
    expect_out("i_neg", 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    drive(1'b1, 32'h7FF00093, 3'b000); tick();
    expect_out("i_pos", 32'h000007FF, 1'b0, 64'h00000000_000007FF, 1'b0);
    drive(1'b1, 32'hFE000C23, 3'b001); tick();
    expect_out("s_neg", 32'hFFFFFFF8, 1'b0, 64'hFFFFFFFF_FFFFFFF8, 1'b0);
    drive(1'b1, 32'hFE000EE3, 3'b010); tick();
    expect_out("b_neg", 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    drive(1'b1, 32'h0080006F, 3'b011); tick();
    expect_out("j_pos", 32'h00000008, 1'b0, 64'h00000000_00000008, 1'b0);
    drive(1'b1, 32'h80000037, 3'b100); tick();
    expect_out("u_neg", 32'h80000000, 1'b0, 64'hFFFFFFFF_80000000, 1'b0);
    drive(1'b1, 32'h123450B7, 3'b100); tick();
    expect_out("u_pos", 32'h12345000, 1'b0, 64'h00000000_12345000, 1'b0);
    drive(1'b1, 32'h02F00013, 3'b101); tick();
    expect_out("shamt25", 32'h0000000F, 1'b1, 64'h00000000_0000002F, 1'b0);
    drive(1'b1, 32'h00F00013, 3'b101); tick();
    expect_out("shamt_ok", 32'h0000000F, 1'b0, 64'h00000000_0000000F, 1'b0);
    drive(1'b1, 32'h000F8073, 3'b110); tick();
    expect_out("zimm", 32'h0000001F, 1'b0, 64'h00000000_0000001F, 1'b0);
    drive(1'b1, 32'hFFFFFFFF, 3'b111); tick();
    expect_out("illegal", 32'h0, 1'b1, 64'h0, 1'b1);
    drive(1'b0, 32'h0, 3'b000); tick();
    check("drain.out_valid", 64'(out_valid32), 64'd0);
    check("drain.in_ready",  64'(in_ready32), 64'd1);

    // Backpressure: A to output register, B to skid, C held off.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'b000); tick();
    check("bp.a_out", 64'(imm32), 64'd1);
    check("bp.ready1", 64'(in_ready32), 64'd1);
    drive(1'b1, 32'h00200093, 3'b000); tick();
    check("bp.a_hold", 64'(imm32), 64'd1);
    check("bp.ready0", 64'(in_ready32), 64'd0);
    drive(1'b1, 32'h00300093, 3'b000); tick();
    check("bp.a_stable", 64'(imm32), 64'd1);
    check("bp.valid", 64'(out_valid32), 64'd1);
    check("bp.ready0b", 64'(in_ready64), 64'd0);
    check("bp.a_stable64", imm64, 64'd1);
    out_ready = 1'b1;
    tick();
    check("bp.b_out", 64'(imm32), 64'd2);
    check("bp.b_valid", 64'(out_valid32), 64'd1);
    check("bp.ready_rec", 64'(in_ready32), 64'd1);
    tick();
    check("bp.c_out", 64'(imm32), 64'd3);
    check("bp.c_valid", 64'(out_valid32), 64'd1);
    drive(1'b0, 32'h0, 3'b000); tick();
    check("bp.empty", 64'(out_valid32), 64'd0);

    // Flush in TWO with a new entry presented: everything is dropped.
    out_ready = 1'b0;
    drive(1'b1, 32'h00400093, 3'b000); tick();
    drive(1'b1, 32'h00500093, 3'b000); tick();
    check("fl.full", 64'(in_ready32), 64'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h00600093, 3'b000); tick();
    check("fl.out_valid", 64'(out_valid32), 64'd0);
    check("fl.in_ready",  64'(in_ready32), 64'd1);
    flush = 1'b0;
    drive(1'b0, 32'h00600093, 3'b000); tick();
    check("fl.no_ghost", 64'(out_valid32), 64'd0);
    drive(1'b1, 32'h00700093, 3'b000); tick();
    check("fl.next_val", 64'(imm32), 64'd7);
    check("fl.next_v",   64'(out_valid32), 64'd1);
    drive(1'b0, 32'h0, 3'b000); tick();

    // Asynchronous reset between edges while holding a result.
    out_ready = 1'b0;
    drive(1'b1, 32'h80000037, 3'b100); tick();
    check("ar.pre", imm64, 64'hFFFFFFFF_80000000);
    drive(1'b0, 32'h0, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.out_valid", 64'(out_valid32), 64'd0);
    check("ar.imm32",     64'(imm32), 64'd0);
    check("ar.imm64",     imm64, 64'd0);
    check("ar.in_ready",  64'(in_ready64), 64'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hFE000EE3, 3'b010); tick();
    check("ar.first_acc", 64'(imm32), 64'h00000000_FFFFFFFC);
    check("ar.first_v",   64'(out_valid32), 64'd1);
    drive(1'b0, 32'h0, 3'b000); tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised successor to the combinational immediate sign-extension unit. It decodes the immediate field of a RISC-V instruction into a sign- or zero-extended XLEN-bit operand. It supports I/S/B/J/U formats plus shift-amount and CSR-zimm forms, and flags illegal selects. It sits between decode and the execute/ALU operand mux. A valid/ready handshake and a 2-entry skid buffer let it sit in a pipelined datapath with full throughput and registered backpressure.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous drop of all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  block can accept an entry this cycle.
- Instr  in  25  instruction bits [31:7].
- ImmSrc  in  3  immediate format select.
- out_valid  out  1  ImmExt/ImmSrc_err hold a valid result.
- out_ready  in  1  downstream consumes the result this cycle.
- ImmExt  out  XLEN  extended immediate.
- ImmSrc_err  out  1  illegal select or illegal field, aligned with ImmExt.

## Operation
- ImmSrc decode:
  - 000 I: sext(Instr[31:20]).
  - 001 S: sext({Instr[31:25],Instr[11:7]}).
  - 010 B: sext({Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}).
  - 011 J: sext({Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}).
  - 100 U: sext({Instr[31:12],12'b0}).
  - 101 SHAMT: zext(Instr[25:20]) when XLEN=64. When XLEN=32, zext(Instr[24:20]); Instr[25]=1 sets ImmSrc_err.
  - 110 ZIMM: zext(Instr[19:15]).
  - 111 is illegal: ImmExt=0 and ImmSrc_err=1.
- Sign extension replicates the field MSB (Instr[31]) up to bit XLEN-1. Zero extension fills with 0.
- Decode is combinational on the input side. The result is captured into the buffer on acceptance, where acceptance means in_valid && in_ready.
- Buffer states:
  - EMPTY: no entries.
  - ONE: output register valid.
  - TWO: output register and skid register both valid.
- State transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + !out_ready -> TWO; the new entry goes to the skid register.
  - ONE + accept + out_ready -> ONE; the output register is replaced.
  - ONE + out_ready + no accept -> EMPTY.
  - TWO + out_ready -> ONE; the skid entry moves to the output register.
- in_ready = !(state==TWO). It is a registered function of state only, so there is no combinational path from out_ready to in_ready.
- Entries leave in acceptance order. No entry is lost or duplicated.
- While out_valid && !out_ready, ImmExt and ImmSrc_err hold stable.
- flush has priority over everything:
  - Next state is EMPTY.
  - An entry presented in the flush cycle is dropped.
  - out_ready in the flush cycle is ignored.
- Reset values (asynchronous):
  - state=EMPTY, out_valid=0, ImmExt=0, ImmSrc_err=0, skid contents=0, in_ready=1.
  - These take effect immediately on rst_n falling and hold while rst_n=0.

## Timing
- Latency: accept at edge N -> out_valid=1 with the result after edge N, visible in cycle N+1.
- Throughput: 1 entry/cycle with out_ready held high; the block stays in ONE.
- Backpressure: one extra entry can be accepted after out_ready drops; in_ready falls the cycle after the skid register fills.
- Recovery: in TWO, one out_ready cycle -> ONE with in_ready=1 next cycle.
- Simultaneous accept and consume in TWO is impossible, because in_ready=0 in TWO.
- Reset mid-operation discards both entries. The first accept is possible in the first cycle after rst_n rises.

## Test plan
- I-type: Instr=0xFFF00093[31:7], ImmSrc=000, out_ready=1 -> ImmExt=0xFFFFFFFF and err=0 one cycle after accept.
- B-type: 0xFE000EE3 (beq -4), ImmSrc=010 -> 0xFFFFFFFC. J-type: 0x0080006F, ImmSrc=011 -> 0x00000008.
- U-type with XLEN=64: 0x80000037 -> 0xFFFFFFFF80000000. With XLEN=32: 0x123450B7 -> 0x12345000.
- Backpressure: out_ready=0, present A,B,C back-to-back:
  - A is in the output register, B in the skid register; in_ready=0 and C is held.
  - Raise out_ready -> A, B, C emerge on consecutive cycles with no gaps or duplicates.
- Errors:
  - ImmSrc=111 -> ImmExt=0, err=1.
  - XLEN=32, ImmSrc=101, Instr[25]=1 -> err=1.
  - ImmSrc=110, Instr[19:15]=11111 -> 0x0000001F, err=0.
- Flush and reset:
  - flush in state TWO with in_valid=1 -> out_valid=0 and in_ready=1 next cycle; the flush-cycle input never appears.
  - rst_n pulled low mid-stream (asynchronously, between edges) -> out_valid=0 and ImmExt=0 immediately.
